coin_accumulator: RTL

Upstream stage of the 5-bit stored-amount/overflow block (ex05). Accepts inserted NIS coins through a valid/ready handshake and keeps a running credit. Applies price deductions requested by the vend controller. On cancel, refunds the remaining credit as coins, one coin per handshake. Its `amount` output drives ex05's `amount` input directly.

---
 rtl/vm_pkg.sv | 13 +
 rtl/refund_picker.sv | 16 +
 rtl/coin_accumulator.sv | 73 +++++++
 3 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: coin encodings, FSM states and credit limits shared by the vending datapath.
package vm_pkg;
  localparam int AMT_W = 5;
  localparam int MAX_AMOUNT = 31;
  localparam logic [1:0] COIN_1 = 2'b00;
  localparam logic [1:0] COIN_2 = 2'b01;
  localparam logic [1:0] COIN_5 = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REFUND} state_t;
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] t);
    return t == COIN_10 ? AMT_W'(10) : t == COIN_5 ? AMT_W'(5) : t == COIN_2 ? AMT_W'(2) : AMT_W'(1);
  endfunction
endpackage

// File: rtl/refund_picker.sv
// refund_picker: largest coin from {10,5,2,1} not exceeding the given amount.
module refund_picker
  import vm_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] amount,
  output logic [1:0]       coin,
  output logic [WIDTH-1:0] value
);
  always_comb begin
    coin = amount >= WIDTH'(10) ? COIN_10 : amount >= WIDTH'(5) ? COIN_5 :
           amount >= WIDTH'(2) ? COIN_2 : COIN_1;
    value = WIDTH'(coin_value(coin));
  end
endmodule

// File: rtl/coin_accumulator.sv
// coin_accumulator: accepts coins, applies price deductions and refunds the
// remaining credit one coin per handshake on cancel.
module coin_accumulator
  import vm_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int MAX_AMOUNT = vm_pkg::MAX_AMOUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  output logic             coin_ready,
  input  logic             cancel,
  input  logic             deduct_valid,
  input  logic [WIDTH-1:0] deduct_value,
  output logic             deduct_ack,
  output logic             deduct_nack,
  output logic             coin_reject,
  output logic [WIDTH-1:0] amount,
  output logic             refund_valid,
  output logic [1:0]       refund_coin,
  input  logic             refund_ready,
  output logic             busy
);
  state_t state;
  logic [WIDTH:0] sum;
  logic [1:0] pick_coin;
  logic [WIDTH-1:0] pick_value;
  refund_picker #(.WIDTH(WIDTH)) u_pick (.amount(amount), .coin(pick_coin), .value(pick_value));
  assign sum = {1'b0, amount} + (WIDTH+1)'(coin_value(coin_type));
  assign coin_ready = state != ST_REFUND && !cancel && !deduct_valid;
  assign refund_valid = state == ST_REFUND;
  assign busy = state == ST_REFUND;
  assign refund_coin = refund_valid ? pick_coin : COIN_1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      amount <= '0;
      deduct_ack <= 1'b0;
      deduct_nack <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      deduct_ack <= 1'b0;
      deduct_nack <= 1'b0;
      coin_reject <= 1'b0;
      if (state == ST_REFUND) begin
        if (refund_ready) begin
          amount <= amount - pick_value;
          if (amount == pick_value) state <= ST_IDLE;
        end
      end else if (cancel) begin
        if (amount != '0) state <= ST_REFUND;
      end else if (deduct_valid) begin
        if (deduct_value <= amount) begin
          amount <= amount - deduct_value;
          deduct_ack <= 1'b1;
          state <= amount == deduct_value ? ST_IDLE : ST_HOLD;
        end else begin
          deduct_nack <= 1'b1;
        end
      end else if (coin_valid) begin
        // sum is one bit wider so an overflowing coin is caught before truncation
        if (sum <= (WIDTH+1)'(MAX_AMOUNT)) begin
          amount <= sum[WIDTH-1:0];
          state <= ST_HOLD;
        end else begin
          coin_reject <= 1'b1;
        end
      end
    end
  end
endmodule
